// File: rtl/decode_ctrl_stage_pkg.sv
// Shared decode-stage definitions: opcode and funct7 encodings, the control bundle
// and its illegal-instruction form.
package decode_ctrl_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_I64    = 7'b0011011;
  localparam logic [6:0] OP_R64    = 7'b0111011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       src_a_src;
    logic       jump_reg;
    logic       is_word_op;
    logic       is_muldiv;
    logic       illegal;
  } control_signals_t;

  localparam control_signals_t CTRL_ILLEGAL = '{illegal: 1'b1, default: '0};

  // Register-register funct7 values; the mul/div encoding exists only with the M extension.
  function automatic logic f7_legal(input logic [6:0] f7, input logic en_m);
    case (f7)
      F7_BASE, F7_ALT: return 1'b1;
      F7_MULDIV:       return en_m;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Upstream/downstream handshake bundle of the decode stage, including flush and the
// illegal-instruction counter.
interface decode_ctrl_stage_if #(
  parameter int TAG_W     = 32,
  parameter int ILL_CNT_W = 16
) ();
  logic                                      flush;
  logic                                      in_valid;
  logic                                      in_ready;
  logic [31:0]                               in_instr;
  logic [TAG_W-1:0]                          in_tag;
  logic                                      out_valid;
  logic                                      out_ready;
  decode_ctrl_stage_pkg::control_signals_t   out_ctrl;
  logic [TAG_W-1:0]                          out_tag;
  logic [ILL_CNT_W-1:0]                      ill_count;

  modport master (
    output flush, in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_ctrl, out_tag, ill_count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_ctrl, out_tag, ill_count
  );
endinterface

// File: rtl/decode_ctrl_stage_decode.sv
// Purely combinational main-control decode: 32-bit instruction to control bundle,
// with XLEN gating, optional M extension and illegal-encoding detection.
module ctrl_decode_comb
  import decode_ctrl_stage_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0]      i_instr,
  output control_signals_t o_ctrl
);
  localparam bit IS_RV32 = (XLEN == 32);

  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  logic             w_ill;
  logic             w_unused_bits;
  control_signals_t w_dec;

  assign w_opcode      = i_instr[6:0];
  assign w_funct3      = i_instr[14:12];
  assign w_funct7      = i_instr[31:25];
  assign w_unused_bits = ^{i_instr[24:15], i_instr[11:7]};

  // Field decode per opcode; w_ill collects every reason the encoding is rejected.
  always_comb begin
    w_dec = '0;
    w_ill = 1'b0;
    case (w_opcode)
      OP_LOAD: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = 2'b01;
        w_dec.jump_reg   = 1'b1;
        w_dec.is_word_op = (w_funct3 == 3'b110);
        w_ill = (w_funct3 == 3'b111) ||
                (IS_RV32 && ((w_funct3 == 3'b011) || (w_funct3 == 3'b110)));
      end
      OP_STORE: begin
        w_dec.imm_src   = 3'b001;
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
        w_dec.jump_reg  = 1'b1;
        w_ill = w_funct3[2] || (IS_RV32 && (w_funct3 == 3'b011));
      end
      OP_R, OP_R64: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_op     = 2'b10;
        w_dec.jump_reg   = 1'b1;
        w_dec.is_muldiv  = (w_funct7 == F7_MULDIV) && EN_M;
        w_dec.is_word_op = (w_opcode == OP_R64);
        w_ill = !f7_legal(w_funct7, EN_M) || (IS_RV32 && (w_opcode == OP_R64));
      end
      OP_I, OP_I64: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.alu_op     = 2'b10;
        w_dec.jump_reg   = 1'b1;
        w_dec.is_word_op = (w_opcode == OP_I64) &&
                           ((w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b101));
        w_ill = IS_RV32 && (w_opcode == OP_I64);
      end
      OP_BRANCH: begin
        w_dec.imm_src  = 3'b010;
        w_dec.branch   = 1'b1;
        w_dec.alu_op   = 2'b01;
        w_dec.jump_reg = 1'b1;
      end
      OP_LUI: begin
        w_dec.reg_write  = 1'b1;
        w_dec.imm_src    = 3'b100;
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = 2'b11;
        w_dec.jump_reg   = 1'b1;
      end
      OP_AUIPC: begin
        w_dec.reg_write = 1'b1;
        w_dec.imm_src   = 3'b100;
        w_dec.alu_src   = 1'b1;
        w_dec.src_a_src = 1'b1;
        w_dec.jump_reg  = 1'b1;
      end
      OP_JAL: begin
        w_dec.reg_write  = 1'b1;
        w_dec.imm_src    = 3'b011;
        w_dec.result_src = 2'b10;
        w_dec.jump       = 1'b1;
        w_dec.src_a_src  = 1'b1;
        w_dec.jump_reg   = 1'b1;
      end
      OP_JALR: begin
        // jump_reg stays low: the target comes from rs1, not from the PC adder
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.jump       = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign o_ctrl = w_ill ? CTRL_ILLEGAL : w_dec;

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: output register plus one skid entry behind a valid/ready
// handshake, with flush and a saturating illegal-instruction counter.
module decode_ctrl_stage
  import decode_ctrl_stage_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter bit EN_M      = 1'b1,
  parameter int TAG_W     = 32,
  parameter int ILL_CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  decode_ctrl_stage_if.slave bus
);
  control_signals_t       w_dec;
  logic                   w_in_fire;
  logic                   w_out_free;

  logic                   r_out_valid;
  control_signals_t       r_out_ctrl;
  logic [TAG_W-1:0]       r_out_tag;
  logic                   r_skid_valid;
  control_signals_t       r_skid_ctrl;
  logic [TAG_W-1:0]       r_skid_tag;
  logic [ILL_CNT_W-1:0]   r_ill_count;

  ctrl_decode_comb #(.XLEN(XLEN), .EN_M(EN_M)) u_decode (
    .i_instr (bus.in_instr),
    .o_ctrl  (w_dec)
  );

  // in_ready is the registered "skid empty" flag, so an accepted beat always has a home
  assign w_in_fire  = bus.in_valid && !r_skid_valid;
  assign w_out_free = !r_out_valid || bus.out_ready;

  // Output register and skid entry; the skid drains into the output before new input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_ctrl   <= '0;
      r_out_tag    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_tag   <= '0;
    end else if (bus.flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_ctrl   <= r_skid_ctrl;
        r_out_tag    <= r_skid_tag;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out_valid <= 1'b1;
        r_out_ctrl  <= w_dec;
        r_out_tag   <= bus.in_tag;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_ctrl  <= w_dec;
      r_skid_tag   <= bus.in_tag;
    end else begin
      r_skid_valid <= r_skid_valid;
    end
  end

  // Counts illegal beats at acceptance; a flush in the same cycle drops the beat uncounted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ill_count <= '0;
    end else if (!bus.flush && w_in_fire && w_dec.illegal &&
                 (r_ill_count != {ILL_CNT_W{1'b1}})) begin
      r_ill_count <= r_ill_count + ILL_CNT_W'(1);
    end else begin
      r_ill_count <= r_ill_count;
    end
  end

  assign bus.in_ready  = !r_skid_valid;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ctrl  = r_out_ctrl;
  assign bus.out_tag   = r_out_tag;
  assign bus.ill_count = r_ill_count;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench: three decode stages (RV64+M, RV32+M with 2-bit counter, RV64 without M)
// driven in lockstep; expected bundles are queued at issue and popped by per-DUT monitors.
module tb_decode_ctrl_stage;
  import decode_ctrl_stage_pkg::*;

  typedef struct packed {
    control_signals_t ctrl;
    logic [31:0]      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q_a[$], q_b[$], q_c[$];

  control_signals_t c_addi, c_ld, c_addiw, c_mul, c_add, c_sw, c_beq;
  control_signals_t c_lui, c_jal, c_jalr, c_auipc, c_ill;

  always #5 clk = ~clk;

  decode_ctrl_stage_if #(.TAG_W(32), .ILL_CNT_W(16)) bus_a ();
  decode_ctrl_stage_if #(.TAG_W(32), .ILL_CNT_W(2))  bus_b ();
  decode_ctrl_stage_if #(.TAG_W(32), .ILL_CNT_W(16)) bus_c ();

  assign bus_a.flush = flush;  assign bus_a.in_valid = in_valid;  assign bus_a.in_instr = in_instr;
  assign bus_a.in_tag = in_tag;  assign bus_a.out_ready = out_ready;
  assign bus_b.flush = flush;  assign bus_b.in_valid = in_valid;  assign bus_b.in_instr = in_instr;
  assign bus_b.in_tag = in_tag;  assign bus_b.out_ready = out_ready;
  assign bus_c.flush = flush;  assign bus_c.in_valid = in_valid;  assign bus_c.in_instr = in_instr;
  assign bus_c.in_tag = in_tag;  assign bus_c.out_ready = out_ready;

  decode_ctrl_stage #(.XLEN(64), .EN_M(1'b1), .TAG_W(32), .ILL_CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  decode_ctrl_stage #(.XLEN(32), .EN_M(1'b1), .TAG_W(32), .ILL_CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  decode_ctrl_stage #(.XLEN(64), .EN_M(1'b0), .TAG_W(32), .ILL_CNT_W(16)) u_c (
    .clk(clk), .reset(reset), .bus(bus_c));

  function automatic control_signals_t mk(
    input logic rw, input logic [2:0] imm, input logic als, input logic mw,
    input logic [1:0] rs, input logic br, input logic [1:0] aop, input logic j,
    input logic sa, input logic jr, input logic wo, input logic md);
    control_signals_t c;
    c = '0;
    c.reg_write = rw;  c.imm_src = imm;  c.alu_src = als;  c.mem_write = mw;
    c.result_src = rs; c.branch = br;    c.alu_op = aop;   c.jump = j;
    c.src_a_src = sa;  c.jump_reg = jr;  c.is_word_op = wo; c.is_muldiv = md;
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] tag,
                      input control_signals_t ea, input control_signals_t eb,
                      input control_signals_t ec);
    exp_t e;
    int   n;
    in_instr = ins;
    in_tag   = tag;
    in_valid = 1'b1;
    n = 0;
    while (!bus_a.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: tag %0h never accepted", tag);
      in_valid = 1'b0;
    end else begin
      e.tag = tag;
      e.ctrl = ea;  q_a.push_back(e);
      e.ctrl = eb;  q_b.push_back(e);
      e.ctrl = ec;  q_c.push_back(e);
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) && n < 40) begin
      step();
      n++;
    end
    chk("drain_A", 64'(q_a.size()), 64'd0);
    chk("drain_B", 64'(q_b.size()), 64'd0);
    chk("drain_C", 64'(q_c.size()), 64'd0);
  endtask

  task automatic chk_counts(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c);
    chk({name, "_cnt_A"}, 64'(bus_a.ill_count), 64'(a));
    chk({name, "_cnt_B"}, 64'(bus_b.ill_count), 64'(b));
    chk({name, "_cnt_C"}, 64'(bus_c.ill_count), 64'(c));
  endtask

  // Monitors: every output transfer must match the oldest queued expectation.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (reset === 1'b0 && bus_a.out_valid && bus_a.out_ready) begin
      if (q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL A_unexpected: got tag %0h expected no output", bus_a.out_tag);
      end else begin
        e = q_a.pop_front();
        chk("A_ctrl", 64'(bus_a.out_ctrl), 64'(e.ctrl));
        chk("A_tag", 64'(bus_a.out_tag), 64'(e.tag));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (reset === 1'b0 && bus_b.out_valid && bus_b.out_ready) begin
      if (q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL B_unexpected: got tag %0h expected no output", bus_b.out_tag);
      end else begin
        e = q_b.pop_front();
        chk("B_ctrl", 64'(bus_b.out_ctrl), 64'(e.ctrl));
        chk("B_tag", 64'(bus_b.out_tag), 64'(e.tag));
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (reset === 1'b0 && bus_c.out_valid && bus_c.out_ready) begin
      if (q_c.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL C_unexpected: got tag %0h expected no output", bus_c.out_tag);
      end else begin
        e = q_c.pop_front();
        chk("C_ctrl", 64'(bus_c.out_ctrl), 64'(e.ctrl));
        chk("C_tag", 64'(bus_c.out_tag), 64'(e.tag));
      end
    end
  end

  initial begin
    //            rw  imm     als   mw    rs     br    aop    j     sa    jr    wo    md
    c_addi  = mk(1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    c_ld    = mk(1'b1, 3'b000, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    c_addiw = mk(1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    c_mul   = mk(1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    c_add   = mk(1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    c_sw    = mk(1'b0, 3'b001, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    c_beq   = mk(1'b0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    c_lui   = mk(1'b1, 3'b100, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    c_jal   = mk(1'b1, 3'b011, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    c_jalr  = mk(1'b1, 3'b000, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    c_auipc = mk(1'b1, 3'b100, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    c_ill   = '0;
    c_ill.illegal = 1'b1;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_tag = 32'h0;
    repeat (3) step();
    chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(bus_a.out_ctrl), 64'd0);
    chk("rst_out_tag", 64'(bus_a.out_tag), 64'd0);
    chk("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    chk_counts("rst", 16'd0, 16'd0, 16'd0);
    reset = 1'b0;
    step();

    // Basic decode, one-cycle latency, XLEN and M-extension gating
    out_ready = 1'b1;
    send(32'h00500093, 32'h100, c_addi, c_addi, c_addi);
    chk("lat_out_valid", 64'(bus_a.out_valid), 64'd1);
    chk("lat_out_tag", 64'(bus_a.out_tag), 64'h100);
    send(32'h0000B083, 32'h104, c_ld, c_ill, c_ld);
    send(32'h0010809B, 32'h108, c_addiw, c_ill, c_addiw);
    send(32'h02208033, 32'h10C, c_mul, c_mul, c_ill);
    drain();
    chk_counts("xlen", 16'd0, 16'd2, 16'd1);

    // Backpressure: first to out, second to skid, third waits until out drains
    out_ready = 1'b0;
    send(32'h002081B3, 32'h200, c_add, c_add, c_add);
    send(32'h0020A023, 32'h204, c_sw, c_sw, c_sw);
    chk("skid_in_ready", 64'(bus_a.in_ready), 64'd0);
    chk("stall_tag0", 64'(bus_a.out_tag), 64'h200);
    in_instr = 32'h00208463; in_tag = 32'h208; in_valid = 1'b1;
    q_a.push_back('{c_beq, 32'h208});
    q_b.push_back('{c_beq, 32'h208});
    q_c.push_back('{c_beq, 32'h208});
    step();
    chk("stall_in_ready", 64'(bus_a.in_ready), 64'd0);
    chk("stall_tag1", 64'(bus_a.out_tag), 64'h200);
    chk("stall_ctrl", 64'(bus_a.out_ctrl), 64'(c_add));
    out_ready = 1'b1;
    step();
    chk("ready_reassert", 64'(bus_a.in_ready), 64'd1);
    chk("skid_to_out_tag", 64'(bus_a.out_tag), 64'h204);
    step();
    in_valid = 1'b0;
    drain();

    // Remaining formats, illegal encodings and counter saturation on the 2-bit counter
    send(32'h000122B7, 32'h300, c_lui, c_lui, c_lui);
    send(32'h008000EF, 32'h304, c_jal, c_jal, c_jal);
    send(32'h000080E7, 32'h308, c_jalr, c_jalr, c_jalr);
    send(32'h00000297, 32'h30C, c_auipc, c_auipc, c_auipc);
    send(32'h0020C023, 32'h310, c_ill, c_ill, c_ill);
    send(32'h04208033, 32'h314, c_ill, c_ill, c_ill);
    drain();
    chk_counts("sat1", 16'd2, 16'd3, 16'd3);
    send(32'h0000007F, 32'h318, c_ill, c_ill, c_ill);
    drain();
    chk_counts("sat2", 16'd3, 16'd3, 16'd4);

    // Flush with skid full and input pending: everything dropped
    out_ready = 1'b0;
    send(32'h00500093, 32'h400, c_addi, c_addi, c_addi);
    send(32'h00500093, 32'h404, c_addi, c_addi, c_addi);
    in_instr = 32'h0000007F; in_tag = 32'h408; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus_a.in_ready), 64'd1);
    chk_counts("flush1", 16'd3, 16'd3, 16'd4);
    q_a.delete(); q_b.delete(); q_c.delete();

    // Flush while ready: an illegal input in the flush cycle is neither kept nor counted
    in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("flush2_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk_counts("flush2", 16'd3, 16'd3, 16'd4);

    out_ready = 1'b1;
    send(32'h00500093, 32'h500, c_addi, c_addi, c_addi);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
